// File: rtl/dff_pkg.sv
// Shared constants and types for the dff_en_reg storage register.
// Optional build macro: DFF_BIT_WEN_EN (per-bit write enable).
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 1;
  localparam int DFF_MAX_WIDTH     = 64;

  localparam logic [DFF_MAX_WIDTH-1:0] DFF_RST_ZERO = '0;

  typedef logic [15:0] dff_word_t;

endpackage

// File: rtl/dff_bit.sv
// Single-bit storage cell: synchronous active-high reset, then write enable, else hold.
module dff_bit
  import dff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic wen,
  output logic q
);

  // The and/or mux (rather than if (wen)) lets an unknown enable show up as X on q
  // instead of silently holding the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= (d & wen) | (q & ~wen);
    end
  end

endmodule

// File: rtl/dff_en_reg.sv
// Parameterised write-enabled register built from WIDTH dff_bit cells.
// Optional build macro: DFF_BIT_WEN_EN widens wen to one enable per bit.
module dff_en_reg
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = DFF_RST_ZERO[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
`ifdef DFF_BIT_WEN_EN
  input  logic [WIDTH-1:0] wen,
`else
  input  logic             wen,
`endif
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_width_check
    $error("dff_en_reg: WIDTH %0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic wen_bit;
`ifdef DFF_BIT_WEN_EN
    assign wen_bit = wen[i];
`else
    assign wen_bit = wen;
`endif
    dff_bit #(
      .RST_VAL (RST_VAL[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .d   (d[i]),
      .wen (wen_bit),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_dff_en_reg.sv
// Self-checking bench for dff_en_reg: vector table, corner sequences, random vs model.
module tb_dff_en_reg;

`ifdef DFF_BIT_WEN_EN
  localparam bit PER_BIT = 1'b1;
  localparam int W16 = 16;
  localparam int W3  = 3;
  localparam int W8  = 8;
`else
  localparam bit PER_BIT = 1'b0;
  localparam int W16 = 1;
  localparam int W3  = 1;
  localparam int W8  = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic           rst16, rst3, rstc, rst8;
  logic [15:0]    d16, q16;
  logic [W16-1:0] wen16;
  logic [2:0]     d3, q3;
  logic [W3-1:0]  wen3;
  logic [2:0]     dc, qc;
  logic [W3-1:0]  wenc;
  logic [7:0]     d8, q8;
  logic [W8-1:0]  wen8;

  dff_en_reg #(.WIDTH(16), .RST_VAL(16'h0000)) u16 (
    .clk(clk), .rst(rst16), .d(d16), .wen(wen16), .q(q16));
  dff_en_reg #(.WIDTH(3), .RST_VAL(3'b101)) u3 (
    .clk(clk), .rst(rst3), .d(d3), .wen(wen3), .q(q3));
  dff_en_reg #(.WIDTH(3), .RST_VAL(3'b000)) ucnt (
    .clk(clk), .rst(rstc), .d(dc), .wen(wenc), .q(qc));
  dff_en_reg #(.WIDTH(8), .RST_VAL(8'h00)) u8 (
    .clk(clk), .rst(rst8), .d(d8), .wen(wen8), .q(q8));

  assign dc = qc + 3'd1;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [15:0] d;
    logic [15:0] exp_q;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_next(input logic r, input logic [W16-1:0] w,
                                             input logic [15:0] dv, input logic [15:0] cur);
    logic [15:0] mask;
    for (int i = 0; i < 16; i++) mask[i] = PER_BIT ? w[i % W16] : w[0];
    if (r) return 16'h0000;
    return (dv & mask) | (cur & ~mask);
  endfunction

  vec_t vecs[7];
  logic [15:0] mq;

  initial begin
    rst16 = 1'b0; wen16 = '0; d16 = '0;
    rst3  = 1'b0; wen3  = '0; d3  = '0;
    rstc  = 1'b0; wenc  = '0;
    rst8  = 1'b0; wen8  = '0; d8  = '0;

    vecs[0] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, "reset_wins_over_wen"};
    vecs[1] = '{1'b0, 1'b1, 16'hCAFE, 16'hCAFE, "write_cafe"};
    vecs[2] = '{1'b0, 1'b0, 16'h1234, 16'hCAFE, "hold_1"};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 16'hCAFE, "hold_2"};
    vecs[4] = '{1'b0, 1'b0, 16'h1234, 16'hCAFE, "hold_3"};
    vecs[5] = '{1'b0, 1'b1, 16'h5A5A, 16'h5A5A, "pipeline_1"};
    vecs[6] = '{1'b0, 1'b1, 16'hCAFE, 16'hCAFE, "pipeline_2"};

    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rst16 = vecs[i].rst;
      wen16 = {W16{vecs[i].wen}};
      d16   = vecs[i].d;
      step();
      check(vecs[i].name, 64'(q16), 64'(vecs[i].exp_q));
    end

    // Reset raised mid-cycle must not act until the next rising edge.
    wen16 = '0;
    d16   = 16'h1234;
    #1 rst16 = 1'b1;
    #1 check("sync_reset_no_edge", 64'(q16), 64'(16'hCAFE));
    step();
    check("sync_reset_at_edge", 64'(q16), 64'(16'h0000));
    rst16 = 1'b0;

    // Non-zero reset value.
    rst3 = 1'b1; wen3 = '1; d3 = 3'b010;
    step();
    check("rstval_101", 64'(q3), 64'(3'b101));
    rst3 = 1'b0;
    step();
    check("rstval_then_write", 64'(q3), 64'(3'b010));
    wen3 = '0; d3 = 3'b111;
    step();
    check("rstval_hold", 64'(q3), 64'(3'b010));

    // Counter: q feeds back as q+1.
    rstc = 1'b1; wenc = '1;
    step();
    check("cnt_reset", 64'(qc), 64'(3'b000));
    rstc = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("cnt_edge_%0d", i), 64'(qc), 64'(i % 8));
    end

    // Partial enable (full-width enable when the per-bit build is off).
    rst8 = 1'b1; wen8 = '1; d8 = 8'hAA;
    step();
    check("w8_reset", 64'(q8), 64'(8'h00));
    rst8 = 1'b0;
    d8 = 8'hFF;
`ifdef DFF_BIT_WEN_EN
    wen8 = 8'b0000_1111;
    step();
    check("w8_partial_wen", 64'(q8), 64'(8'h0F));
`else
    wen8 = 1'b1;
    step();
    check("w8_full_wen", 64'(q8), 64'(8'hFF));
`endif
    rst8 = 1'b1;
    step();
    check("w8_reset_after", 64'(q8), 64'(8'h00));
    rst8 = 1'b0;

    // Random traffic against the reference model.
    rst16 = 1'b1; wen16 = '0;
    step();
    mq = 16'h0000;
    check("rand_start", 64'(q16), 64'(mq));
    for (int n = 0; n < 300; n++) begin
      rst16 = ($urandom_range(0, 11) == 0);
      wen16 = W16'($urandom);
      d16   = 16'($urandom);
      mq = model_next(rst16, wen16, d16, mq);
      step();
      check($sformatf("rand_%0d", n), 64'(q16), 64'(mq));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_en_reg.md
Name: dff_en_reg

Overview:
- Parameterised write-enabled D-type storage register with synchronous, active-high reset.
- It is the base state element of the design: FSM state bits, counters, and the cache data/tag cell arrays.
- WIDTH=1 is the default single-bit flop used throughout. Wider instances replace banks of single-bit flops.

Parameters:
- WIDTH, 1, number of stored bits (legal range 1..64).
- RST_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high. Clock is clk.
- d  input  WIDTH  next data.
- wen  input  1  write enable; active-high. Becomes WIDTH bits when DFF_BIT_WEN_EN is defined.
- q  output  WIDTH  stored value, driven directly from the flops.

Behaviour:
- All state updates happen only on the rising edge of clk. No asynchronous paths.
- Priority at each rising edge:
  - rst=1: q <= RST_VAL. This applies regardless of wen and d.
  - else wen=1: q <= d.
  - else: q holds.
- Reset value: q = RST_VAL (default 0) from the first edge where rst=1.
- Before the first reset, q is X in simulation. It must not be forced.
- Latency: one cycle. A d value sampled at edge N appears on q after edge N. There is no combinational path from d, wen or rst to q.
- Reset asserted mid-operation: reset wins, q goes to RST_VAL at that edge. The first write after reset is taken at the first edge where rst=0 and wen=1.
- wen and rst high together: the reset value is loaded and d is ignored.
- wen held high continuously: the register acts as a plain pipeline flop.
- X/Z on wen while rst=0 must not corrupt q silently. The simulation model propagates X to q, with no pessimistic hold.
- q is always driven. The block has no tri-state output; tri-state read muxing belongs to the enclosing cell.
- Width rules:
  - d, q and RST_VAL are exactly WIDTH bits.
  - A RST_VAL that is wider than WIDTH is a width mismatch. Elaboration flags it with a lint error.

Optional Feature:
- Macro: DFF_BIT_WEN_EN.
- Defined:
  - wen is WIDTH bits wide.
  - Bit i of q updates from d[i] only when wen[i]=1.
  - Reset still loads all bits.
- Undefined:
  - wen is 1 bit and gates all bits together.
  - Behaviour is identical to the defined case with wen replicated WIDTH times.

Decomposition:
- Shared package dff_pkg holds:
  - DFF_DEFAULT_WIDTH = 1.
  - A helper constant for the all-zero reset value.
  - The typedef for the 16-bit data word.
- Sub-module dff_bit: the single-bit reset/enable cell. It is instantiated WIDTH times through a generate loop, with per-bit wen when DFF_BIT_WEN_EN is defined.

Test Plan:
- Reset only, WIDTH=16, RST_VAL=16'h0000: rst=1, wen=1, d=16'hFFFF for 1 edge -> q=16'h0000.
- Write then hold: rst=0, wen=1, d=16'hCAFE -> q=16'hCAFE after the edge. Then wen=0, d=16'h1234 for 3 edges -> q stays 16'hCAFE.
- Synchronous reset with no clock edge: q=16'hCAFE, rst rises mid-cycle -> q unchanged until the next rising edge, then q=16'h0000.
- Non-zero reset value, WIDTH=3, RST_VAL=3'b101: reset -> q=3'b101. Then wen=1, d=3'b010 -> q=3'b010.
- Counter use, WIDTH=3, wen=1, d=q+1 each edge after reset to 3'b000:
  - After 7 edges q=3'b111.
  - On the 8th edge q wraps to 3'b000.
- DFF_BIT_WEN_EN defined, WIDTH=8, q=8'h00: wen=8'b0000_1111, d=8'hFF -> q=8'h0F. Then rst=1 -> q=8'h00.
